multicycle_controller: RTL
==========================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have one clock and one reset: the reset is synchronous and active-high.
REQ-002 SHALL have these ports, in this order:
  clk  in  1  rising-edge clock
  rst  in  1  synchronous reset, active-high
  op  in  7  opcode from instruction register
  funct3  in  3  instr[14:12]
  funct7b5  in  1  instr[30]
  zero  in  1  ALU zero flag
  mem_ready  in  1  memory completes access this cycle
  PCWrite  out  1  PC register enable
  AdrSrc  out  1  0=PC, 1=ALU result register
  MemWrite  out  1  data memory write
  IRWrite  out  1  instruction register enable
  RegWrite  out  1  register file write
  ResultSrc  out  2  00=ALUOut, 01=mem data, 10=ALU result
  ALUSrcA  out  2  00=PC, 01=OldPC, 10=rs1 data
  ALUSrcB  out  2  00=rs2 data, 01=immediate, 10=constant 4
  ImmSrc  out  2  00=I, 01=S, 10=B, 11=J
  ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
  instr_done  out  1  one-cycle pulse on the final cycle of each instruction
  illegal  out  1  one-cycle pulse in DECODE for an unsupported opcode
  state  out  4  current state encoding, for debug

Function
REQ-003 SHALL implement a Moore FSM with these encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, ALUWB=7, EXECUTEI=8, JAL=9, BEQ=10; codes 11-15 SHALL go to FETCH.
REQ-004 FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10; IRWrite=PCWrite=mem_ready; stays in FETCH while mem_ready=0; else goes to DECODE.
REQ-005 DECODE: ALUSrcA=01, ALUSrcB=01, add. Next state by op:
  0000011 or 0100011 -> MEMADR
  0110011 -> EXECUTER
  0010011 -> EXECUTEI
  1100011 -> BEQ
  1101111 -> JAL
  any other op -> FETCH with illegal=1
REQ-006 MEMADR: ALUSrcA=10, ALUSrcB=01, add; op[5]=0 -> MEMREAD, op[5]=1 -> MEMWRITE.
REQ-007 MEMREAD: AdrSrc=1, ResultSrc=00; holds until mem_ready, then -> MEMWB.
REQ-008 MEMWB: ResultSrc=01, RegWrite=1, instr_done=1 -> FETCH.
REQ-009 MEMWRITE: AdrSrc=1, MemWrite=1 for every cycle in this state; holds until mem_ready; on exit instr_done=1 -> FETCH.
REQ-010 EXECUTER: ALUSrcA=10, ALUSrcB=00, function decode -> ALUWB. EXECUTEI: ALUSrcA=10, ALUSrcB=01, function decode -> ALUWB.
REQ-011 ALUWB: ResultSrc=00, RegWrite=1, instr_done=1 -> FETCH.
REQ-012 BEQ: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00, PCWrite=zero, instr_done=1 -> FETCH.
REQ-013 JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1 -> ALUWB.
REQ-014 ImmSrc SHALL decode from op in every state:
  lw / I-type -> 00
  sw -> 01
  beq -> 10
  jal -> 11
  otherwise -> 00
REQ-015 Function decode (funct3): 000 -> sub if op[5]&funct7b5, else add; 010 -> slt; 110 -> or; 111 -> and; any other funct3 -> add.
REQ-016 In any state not listed as asserting a strobe, SHALL drive PCWrite, IRWrite, MemWrite, RegWrite, instr_done and illegal low. Unlisted mux selects SHALL be 00.
REQ-017 Latency with mem_ready tied high, in cycles: lw 5, sw 4, R-type 4, I-type 4, jal 4, beq 3.

Reset
REQ-018 With rst=1 at a clock edge, state SHALL become FETCH regardless of the current state, including mid-MEMWRITE.
REQ-019 While rst=1, PCWrite, IRWrite, MemWrite, RegWrite, instr_done and illegal SHALL be forced 0.
REQ-020 After reset, the first fetch SHALL begin on the first cycle with rst=0.

Configuration
REQ-021 Macro MC_JAL_EN: when defined, jal SHALL follow REQ-005/REQ-013. When undefined, the JAL state SHALL be absent and op 1101111 SHALL be treated as illegal, with ImmSrc 00 for that op.

Verification
REQ-022 Reset then lw (op 0000011), mem_ready=1 -> states 0,1,2,3,4; RegWrite=1 only in state 4; instr_done pulses once; 5 cycles.
REQ-023 sw with mem_ready low for 3 cycles in MEMWRITE -> MemWrite=1 for 4 cycles; exit on the ready cycle; no RegWrite.
REQ-024 R-type, funct3=000, funct7b5=1 -> ALUControl=001 in EXECUTER. Same fields on I-type (op 0010011) -> ALUControl=000.
REQ-025 beq with zero=1 -> PCWrite=1 in BEQ. With zero=0 -> PCWrite=0. Both cases return to FETCH after 3 cycles.
REQ-026 op 1111111 -> illegal=1 in DECODE, then FETCH. jal with MC_JAL_EN undefined -> same result.
REQ-027 rst asserted during MEMWRITE with mem_ready=0 -> next state FETCH; MemWrite=0 in the reset cycle.

Source files
------------

// File: rtl/multicycle_controller.sv
// Multicycle RV32 subset control FSM: lw, sw, R-type, I-type ALU, beq, and jal when MC_JAL_EN is defined.
// The state is registered; strobes and selects decode from it, qualified by mem_ready, zero and rst.
module multicycle_controller (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       instr_done,
    output logic       illegal,
    output logic [3:0] state
);
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECUTEI = 4'd8,
`ifdef MC_JAL_EN
        S_JAL      = 4'd9,
`endif
        S_BEQ      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    typedef struct packed {
        logic       pcw;
        logic       adr;
        logic       mw;
        logic       irw;
        logic       rw;
        logic       done;
        logic       ill;
        logic [1:0] rs;
        logic [1:0] sa;
        logic [1:0] sb;
        logic [2:0] alu;
    } ctrl_t;

    state_t     cur;
    ctrl_t      c;
    logic [2:0] fn_alu;
    logic       op_known;

    always_ff @(posedge clk) begin
        if (rst) begin
            cur <= S_FETCH;
        end else begin
            case (cur)
                S_FETCH:    if (mem_ready) cur <= S_DECODE;
                S_DECODE: begin
                    case (op)
                        OP_LOAD, OP_STORE: cur <= S_MEMADR;
                        OP_RTYPE:          cur <= S_EXECUTER;
                        OP_ITYPE:          cur <= S_EXECUTEI;
                        OP_BRANCH:         cur <= S_BEQ;
`ifdef MC_JAL_EN
                        OP_JAL:            cur <= S_JAL;
`endif
                        default:           cur <= S_FETCH;
                    endcase
                end
                S_MEMADR:   cur <= op[5] ? S_MEMWRITE : S_MEMREAD;
                S_MEMREAD:  if (mem_ready) cur <= S_MEMWB;
                S_MEMWB:    cur <= S_FETCH;
                S_MEMWRITE: if (mem_ready) cur <= S_FETCH;
                S_EXECUTER: cur <= S_ALUWB;
                S_EXECUTEI: cur <= S_ALUWB;
                S_ALUWB:    cur <= S_FETCH;
                S_BEQ:      cur <= S_FETCH;
`ifdef MC_JAL_EN
                S_JAL:      cur <= S_ALUWB;
`endif
                default:    cur <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        case (op)
            OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH: op_known = 1'b1;
`ifdef MC_JAL_EN
            OP_JAL:  op_known = 1'b1;
`endif
            default: op_known = 1'b0;
        endcase
    end

    // Only R-type (op[5]=1) can turn funct3=000 into a subtract; addi stays add.
    always_comb begin
        case (funct3)
            3'b000:  fn_alu = (op[5] & funct7b5) ? ALU_SUB : ALU_ADD;
            3'b010:  fn_alu = ALU_SLT;
            3'b110:  fn_alu = ALU_OR;
            3'b111:  fn_alu = ALU_AND;
            default: fn_alu = ALU_ADD;
        endcase
    end

    always_comb begin
        case (op)
            OP_STORE:  ImmSrc = 2'b01;
            OP_BRANCH: ImmSrc = 2'b10;
`ifdef MC_JAL_EN
            OP_JAL:    ImmSrc = 2'b11;
`endif
            default:   ImmSrc = 2'b00;
        endcase
    end

    always_comb begin
        c = '0;
        case (cur)
            S_FETCH: begin
                c.sb  = 2'b10;
                c.rs  = 2'b10;
                c.pcw = mem_ready;
                c.irw = mem_ready;
            end
            S_DECODE: begin
                c.sa  = 2'b01;
                c.sb  = 2'b01;
                c.ill = ~op_known;
            end
            S_MEMADR: begin
                c.sa = 2'b10;
                c.sb = 2'b01;
            end
            S_MEMREAD: c.adr = 1'b1;
            S_MEMWB: begin
                c.rs   = 2'b01;
                c.rw   = 1'b1;
                c.done = 1'b1;
            end
            S_MEMWRITE: begin
                c.adr  = 1'b1;
                c.mw   = 1'b1;
                c.done = mem_ready;
            end
            S_EXECUTER: begin
                c.sa  = 2'b10;
                c.alu = fn_alu;
            end
            S_EXECUTEI: begin
                c.sa  = 2'b10;
                c.sb  = 2'b01;
                c.alu = fn_alu;
            end
            S_ALUWB: begin
                c.rw   = 1'b1;
                c.done = 1'b1;
            end
            S_BEQ: begin
                c.sa   = 2'b10;
                c.alu  = ALU_SUB;
                c.pcw  = zero;
                c.done = 1'b1;
            end
`ifdef MC_JAL_EN
            S_JAL: begin
                c.sa  = 2'b01;
                c.sb  = 2'b10;
                c.pcw = 1'b1;
            end
`endif
            default: ;
        endcase
        // Strobes must be quiet in the reset cycle even though the state still shows the old value.
        if (rst) begin
            c.pcw  = 1'b0;
            c.irw  = 1'b0;
            c.mw   = 1'b0;
            c.rw   = 1'b0;
            c.done = 1'b0;
            c.ill  = 1'b0;
        end
    end

    assign PCWrite    = c.pcw;
    assign AdrSrc     = c.adr;
    assign MemWrite   = c.mw;
    assign IRWrite    = c.irw;
    assign RegWrite   = c.rw;
    assign ResultSrc  = c.rs;
    assign ALUSrcA    = c.sa;
    assign ALUSrcB    = c.sb;
    assign ALUControl = c.alu;
    assign instr_done = c.done;
    assign illegal    = c.ill;
    assign state      = cur;

endmodule
